// File: rtl/segment_pkg.sv
// Shared types and constants for the seven-segment text scroller.
package segment_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SHOW = 2'd2
  } state_t;

  localparam logic [7:0]  ASCII_SPACE        = 8'h20;
  localparam int unsigned DEFAULT_NUM_DIGITS = 6;

endpackage

// File: rtl/scroll_tick_gen.sv
// Free-running step divider: counts 0..DIV-1 while enabled, ticks on terminal count.
module scroll_tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic tick_c
);

  localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] count;

  assign tick_c = enable_i && (count == CNT_W'(DIV - 1));

  // Count is held (not cleared) while disabled so a pause resumes mid-period.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      count <= '0;
    end else if (enable_i) begin
      if (tick_c) count <= '0;
      else        count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/segment_text_scroller_de1soc.sv
// Message buffer and display window for a row of seven-segment digits:
// load ASCII characters, commit, then show static or scrolling text.
module segment_text_scroller_de1soc
  import segment_pkg::*;
#(
  parameter int unsigned MSG_DEPTH  = 32,
  parameter int unsigned NUM_DIGITS = DEFAULT_NUM_DIGITS,
  parameter int unsigned SCROLL_DIV = 25_000_000
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [7:0]                      char_i,
  input  logic                            char_valid_i,
  output logic                            char_ready_o,
  input  logic                            commit_i,
  input  logic                            clear_i,
  input  logic                            pause_i,
  output logic [8*NUM_DIGITS-1:0]         digit_chars_o,
  output logic [$clog2(MSG_DEPTH+1)-1:0]  msg_len_o,
  output logic                            step_o
);

  localparam int unsigned LEN_W = $clog2(MSG_DEPTH + 1);
  localparam int unsigned IDX_W = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
  localparam int unsigned SUM_W = LEN_W + 1;

  state_t           state;
  logic [LEN_W-1:0] len;
  logic [IDX_W-1:0] pos;
  logic [7:0]       buffer [MSG_DEPTH];

  logic                    accept_c;
  logic                    long_c;
  logic                    tick_c;
  logic                    tick_clear_c;
  logic                    tick_enable_c;
  logic [SUM_W-1:0]        sum_c    [NUM_DIGITS];
  logic [IDX_W-1:0]        rd_idx_c [NUM_DIGITS];
  logic [8*NUM_DIGITS-1:0] window_c;

  assign msg_len_o    = len;
  assign char_ready_o = !rst_i && (state != SHOW) && (32'(len) < 32'(MSG_DEPTH));
  // A clear in the same cycle discards the offered character.
  assign accept_c     = char_valid_i && char_ready_o && !clear_i;
  assign long_c       = 32'(len) > 32'(NUM_DIGITS);

  assign tick_clear_c  = clear_i || (state != SHOW);
  assign tick_enable_c = (state == SHOW) && !pause_i && long_c;

  scroll_tick_gen #(
    .DIV (SCROLL_DIV)
  ) u_tick (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (tick_clear_c),
    .enable_i (tick_enable_c),
    .tick_c   (tick_c)
  );

  // Buffer read index per window slot; (pos + k) < 2*len so one subtraction wraps it.
  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++) begin
      sum_c[k] = SUM_W'(pos) + SUM_W'(k);
      if (!long_c) begin
        rd_idx_c[k] = IDX_W'(k);
      end else if (sum_c[k] >= SUM_W'(len)) begin
        rd_idx_c[k] = IDX_W'(sum_c[k] - SUM_W'(len));
      end else begin
        rd_idx_c[k] = IDX_W'(sum_c[k]);
      end
    end
  end

  // Window slot 0 is the leftmost digit, i.e. the top byte of the bus.
  always_comb begin
    window_c = {NUM_DIGITS{ASCII_SPACE}};
    if (state == SHOW) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (long_c || (32'(k) < 32'(len))) begin
          window_c[8*(NUM_DIGITS-1-k) +: 8] = buffer[rd_idx_c[k]];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept_c) buffer[IDX_W'(len)] <= char_i;
  end

  // Control FSM with registered step pulse and display bus.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state         <= IDLE;
      len           <= '0;
      pos           <= '0;
      step_o        <= 1'b0;
      digit_chars_o <= {NUM_DIGITS{ASCII_SPACE}};
    end else begin
      step_o        <= tick_c;
      digit_chars_o <= window_c;
      if (accept_c) len <= len + LEN_W'(1);
      case (state)
        IDLE: begin
          if (accept_c) state <= LOAD;
        end
        LOAD: begin
          if (commit_i && (len != '0)) begin
            state <= SHOW;
            pos   <= '0;
          end
        end
        SHOW: begin
          if (tick_c) begin
            if ((LEN_W'(pos) + LEN_W'(1)) >= len) pos <= '0;
            else                                   pos <= pos + IDX_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_segment_text_scroller_de1soc.sv
// Directed self-checking bench for segment_text_scroller_de1soc (DIV=4, 6 digits, depth 8).
module tb_segment_text_scroller_de1soc;

  localparam int unsigned MSG_DEPTH  = 8;
  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned SCROLL_DIV = 4;

  localparam logic [47:0] SPACES  = 48'h202020202020;
  localparam logic [47:0] W_HELLO = 48'h48454C4C4F20;
  localparam logic [47:0] W_ABCDEF = 48'h414243444546;
  localparam logic [47:0] W_BCDEFG = 48'h424344454647;
  localparam logic [47:0] W_CDEFGH = 48'h434445464748;
  localparam logic [47:0] W_FGHABC = 48'h464748414243;
  localparam logic [47:0] W_X      = 48'h582020202020;

  logic                   clk;
  logic                   rst_i;
  logic [7:0]             char_i;
  logic                   char_valid_i;
  logic                   char_ready_o;
  logic                   commit_i;
  logic                   clear_i;
  logic                   pause_i;
  logic [8*NUM_DIGITS-1:0] digit_chars_o;
  logic [3:0]             msg_len_o;
  logic                   step_o;

  int n_asserts;
  int n_fail;
  int steps;
  int changed;

  segment_text_scroller_de1soc #(
    .MSG_DEPTH  (MSG_DEPTH),
    .NUM_DIGITS (NUM_DIGITS),
    .SCROLL_DIV (SCROLL_DIV)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .char_i        (char_i),
    .char_valid_i  (char_valid_i),
    .char_ready_o  (char_ready_o),
    .commit_i      (commit_i),
    .clear_i       (clear_i),
    .pause_i       (pause_i),
    .digit_chars_o (digit_chars_o),
    .msg_len_o     (msg_len_o),
    .step_o        (step_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n clocks, sampling 1 time unit after each rising edge.
  task automatic cyc(input int n, output int nsteps);
    nsteps = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (step_o === 1'b1) nsteps++;
    end
  endtask

  task automatic send(input logic [7:0] c);
    int s;
    char_i       = c;
    char_valid_i = 1'b1;
    cyc(1, s);
    char_valid_i = 1'b0;
  endtask

  task automatic pulse_commit();
    int s;
    commit_i = 1'b1;
    cyc(1, s);
    commit_i = 1'b0;
  endtask

  initial begin
    n_asserts    = 0;
    n_fail       = 0;
    rst_i        = 1'b1;
    char_i       = 8'h00;
    char_valid_i = 1'b0;
    commit_i     = 1'b0;
    clear_i      = 1'b0;
    pause_i      = 1'b0;

    // Reset state
    cyc(2, steps);
    check("rst_ready",  64'(char_ready_o),  64'(0));
    check("rst_len",    64'(msg_len_o),     64'(0));
    check("rst_digits", 64'(digit_chars_o), 64'(SPACES));
    check("rst_step",   64'(step_o),        64'(0));
    rst_i = 1'b0;
    #1;
    check("post_rst_ready", 64'(char_ready_o), 64'(1));

    // Static short message
    send(8'h48); send(8'h45); send(8'h4C); send(8'h4C); send(8'h4F);
    check("hello_len",         64'(msg_len_o),     64'(5));
    check("hello_load_digits", 64'(digit_chars_o), 64'(SPACES));
    pulse_commit();
    check("hello_lag_digits",  64'(digit_chars_o), 64'(SPACES));
    check("hello_show_ready",  64'(char_ready_o),  64'(0));
    cyc(1, steps);
    check("hello_digits", 64'(digit_chars_o), 64'(W_HELLO));
    changed = 0;
    steps   = 0;
    for (int i = 0; i < 100; i++) begin
      int s;
      cyc(1, s);
      steps += s;
      if (digit_chars_o !== W_HELLO) changed++;
    end
    check("hello_no_step", 64'(steps),   64'(0));
    check("hello_static",  64'(changed), 64'(0));
    send(8'h5A);
    check("show_write_ignored", 64'(msg_len_o), 64'(5));

    // Clear wins over a simultaneous write
    char_i       = 8'h51;
    char_valid_i = 1'b1;
    clear_i      = 1'b1;
    cyc(1, steps);
    char_valid_i = 1'b0;
    clear_i      = 1'b0;
    check("clear_len",    64'(msg_len_o),     64'(0));
    check("clear_digits", 64'(digit_chars_o), 64'(SPACES));
    check("clear_ready",  64'(char_ready_o),  64'(1));

    // Commit with empty message is ignored
    pulse_commit();
    cyc(2, steps);
    check("empty_commit_digits", 64'(digit_chars_o), 64'(SPACES));
    check("empty_commit_ready",  64'(char_ready_o),  64'(1));

    // Overflow: 9 chars with valid held, only 8 fit
    for (int i = 0; i < 9; i++) begin
      int s;
      char_i       = 8'(8'h41 + i);
      char_valid_i = 1'b1;
      cyc(1, s);
    end
    char_valid_i = 1'b0;
    check("full_len",   64'(msg_len_o),    64'(8));
    check("full_ready", 64'(char_ready_o), 64'(0));

    // Scrolling with wrap
    pulse_commit();
    cyc(1, steps);
    check("scroll_start", 64'(digit_chars_o), 64'(W_ABCDEF));
    cyc(7, steps);
    check("scroll_steps_2",  64'(steps),  64'(2));
    check("scroll_step_c8",  64'(step_o), 64'(1));
    cyc(1, steps);
    check("scroll_cdefgh", 64'(digit_chars_o), 64'(W_CDEFGH));
    cyc(12, steps);
    check("scroll_steps_5", 64'(steps),         64'(3));
    check("scroll_fghabc",  64'(digit_chars_o), 64'(W_FGHABC));
    cyc(11, steps);
    check("scroll_steps_8", 64'(steps),  64'(3));
    check("scroll_step_c32", 64'(step_o), 64'(1));
    cyc(1, steps);
    check("scroll_wrap", 64'(digit_chars_o), 64'(W_ABCDEF));

    // Pause holds divider and window
    cyc(1, steps);
    pause_i = 1'b1;
    cyc(10, steps);
    check("pause_no_step", 64'(steps),         64'(0));
    check("pause_window",  64'(digit_chars_o), 64'(W_ABCDEF));
    pause_i = 1'b0;
    cyc(1, steps);
    check("resume_step_early", 64'(step_o), 64'(0));
    cyc(1, steps);
    check("resume_step", 64'(step_o), 64'(1));
    cyc(1, steps);
    check("resume_window", 64'(digit_chars_o), 64'(W_BCDEFG));

    // Reset mid-show
    rst_i = 1'b1;
    cyc(1, steps);
    check("midrst_digits", 64'(digit_chars_o), 64'(SPACES));
    check("midrst_len",    64'(msg_len_o),     64'(0));
    check("midrst_ready",  64'(char_ready_o),  64'(0));
    check("midrst_step",   64'(step_o),        64'(0));
    rst_i = 1'b0;
    #1;
    check("midrst_release_ready", 64'(char_ready_o), 64'(1));
    pulse_commit();
    cyc(2, steps);
    check("midrst_commit_ignored", 64'(digit_chars_o), 64'(SPACES));
    check("midrst_commit_ready",   64'(char_ready_o),  64'(1));

    // Single-character message shows statically
    send(8'h58);
    check("one_len", 64'(msg_len_o), 64'(1));
    pulse_commit();
    cyc(1, steps);
    check("one_digits", 64'(digit_chars_o), 64'(W_X));
    cyc(20, steps);
    check("one_no_step", 64'(steps),         64'(0));
    check("one_static",  64'(digit_chars_o), 64'(W_X));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
